// File: rtl/la_ao_pipe_pkg.sv
// rtl/la_ao_pipe_pkg.sv - shared helpers for the pipelined AND-OR array
package la_ao_pipe_pkg;

  // A zero-width direct-input group still needs a one-bit port.
  function automatic int max1(input int n);
    return (n > 0) ? n : 1;
  endfunction

endpackage

// File: rtl/la_ao_pipe_stage.sv
// rtl/la_ao_pipe_stage.sv - one-entry elastic valid/ready register slot
module la_ao_pipe_stage #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_load;

  assign i_ready = ~r_valid | o_ready;
  assign w_load  = i_valid & i_ready & ~clear;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (clear)
        r_valid <= 1'b0;
      else if (w_load)
        r_valid <= 1'b1;
      else if (o_ready)
        r_valid <= 1'b0;
      if (w_load)
        r_data <= i_data;
    end
  end

endmodule

// File: rtl/la_ao_pipe.sv
// rtl/la_ao_pipe.sv - W-lane AND-OR(-invert) array with 0..2 elastic register stages
module la_ao_pipe
  import la_ao_pipe_pkg::*;
#(
  parameter int W    = 1,
  parameter int NT   = 1,
  parameter int NA   = 3,
  parameter int NB   = 1,
  parameter int INV  = 0,
  parameter int PIPE = 2,
  parameter     PROP = "DEFAULT"
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W*NT*NA-1:0]      a,
  input  logic [W*max1(NB)-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            z
);

  localparam int LW  = NT + NB;
  localparam int S1W = W * LW;

  // Per lane: NT term bits in the low slots, then the NB direct inputs.
  logic [S1W-1:0] w_s1_in;
  logic [S1W-1:0] w_or_src;
  logic [W-1:0]   w_res;

  for (genvar l = 0; l < W; l++) begin : g_lane
    for (genvar t = 0; t < NT; t++) begin : g_term
      assign w_s1_in[l*LW+t] = &a[(l*NT+t)*NA +: NA];
    end
    if (NB > 0) begin : g_b
      assign w_s1_in[l*LW+NT +: NB] = b[l*NB +: NB];
    end
    assign w_res[l] = (INV != 0) ^ (|w_or_src[l*LW +: LW]);
  end

  if (PIPE == 0) begin : g_pipe0
    assign w_or_src  = w_s1_in;
    assign z         = w_res;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
  end else if (PIPE == 1) begin : g_pipe1
    assign w_or_src = w_s1_in;
    la_ao_pipe_stage #(.DW(W)) u_s2 (
      .clk     (clk),
      .nreset  (nreset),
      .clear   (clear),
      .i_valid (in_valid),
      .i_ready (in_ready),
      .i_data  (w_res),
      .o_valid (out_valid),
      .o_ready (out_ready),
      .o_data  (z)
    );
  end else begin : g_pipe2
    logic w_s1_valid;
    logic w_s1_ready;
    la_ao_pipe_stage #(.DW(S1W)) u_s1 (
      .clk     (clk),
      .nreset  (nreset),
      .clear   (clear),
      .i_valid (in_valid),
      .i_ready (in_ready),
      .i_data  (w_s1_in),
      .o_valid (w_s1_valid),
      .o_ready (w_s1_ready),
      .o_data  (w_or_src)
    );
    la_ao_pipe_stage #(.DW(W)) u_s2 (
      .clk     (clk),
      .nreset  (nreset),
      .clear   (clear),
      .i_valid (w_s1_valid),
      .i_ready (w_s1_ready),
      .i_data  (w_res),
      .o_valid (out_valid),
      .o_ready (out_ready),
      .o_data  (z)
    );
  end

endmodule
